// File: rtl/tdm_pkg.sv
// Shared TDM definitions: slot encoding, FSM states, default lane width.
// Used by both the transmit-side mux and the receive-side demux.
package tdm_pkg;

    localparam int TDM_WIDTH = 1;

    localparam logic SLOT_D0 = 1'b0;
    localparam logic SLOT_D1 = 1'b1;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        SLOT0 = 2'd1,
        SLOT1 = 2'd2
    } tdm_state_e;

endpackage

// File: rtl/tdm_slot_fsm.sv
// Slot tracker for the TDM receiver: follows the sync marker and
// issues capture enables and a registered slot-order error pulse.
module tdm_slot_fsm
    import tdm_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_valid,
    input  logic i_sync,
    output logic o_a,
    output logic o_locked,
    output logic o_cap_d0,
    output logic o_cap_frame,
    output logic o_sync_err
);

    tdm_state_e state;
    tdm_state_e state_nxt;
    logic       err_nxt;

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        if (i_valid) begin
            unique case (state)
                HUNT: begin
                    if (i_sync) state_nxt = SLOT1;
                end
                SLOT0: begin
                    if (i_sync) begin
                        state_nxt = SLOT1;
                    end else begin
                        state_nxt = HUNT;
                        err_nxt   = 1'b1;
                    end
                end
                SLOT1: begin
                    // A sync here restarts the frame without a HUNT pass
                    if (i_sync) begin
                        err_nxt = 1'b1;
                    end else begin
                        state_nxt = SLOT0;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= HUNT;
            o_sync_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            o_sync_err <= err_nxt;
        end
    end

    assign o_cap_d0    = i_valid & i_sync;
    assign o_cap_frame = i_valid & ~i_sync & (state == SLOT1);
    assign o_a         = (state == SLOT1) ? SLOT_D1 : SLOT_D0;
    assign o_locked    = (state == SLOT0) || (state == SLOT1);

endmodule

// File: rtl/tdm_demux2.sv
// Two-channel TDM demultiplexer with frame-aligned registered outputs.
// Optional saturating sync-error counter: define TDM_DEMUX_ERRCNT_EN.
module tdm_demux2
    import tdm_pkg::*;
#(
    parameter int WIDTH     = TDM_WIDTH,
    parameter int ERR_CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_y,
    input  logic             i_valid,
    input  logic             i_sync,
`ifdef TDM_DEMUX_ERRCNT_EN
    input  logic             i_err_clr,
    output logic [ERR_CNT_W-1:0] o_err_cnt,
`endif
    output logic [WIDTH-1:0] o_d0,
    output logic [WIDTH-1:0] o_d1,
    output logic             o_a,
    output logic             o_frame_valid,
    output logic             o_locked,
    output logic             o_sync_err
);

    logic             cap_d0;
    logic             cap_frame;
    logic [WIDTH-1:0] shadow_d0;

    tdm_slot_fsm u_fsm (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .i_sync      (i_sync),
        .o_a         (o_a),
        .o_locked    (o_locked),
        .o_cap_d0    (cap_d0),
        .o_cap_frame (cap_frame),
        .o_sync_err  (o_sync_err)
    );

    // Both channels load on one edge so the pair is never half-updated
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            shadow_d0     <= '0;
            o_d0          <= '0;
            o_d1          <= '0;
            o_frame_valid <= 1'b0;
        end else begin
            o_frame_valid <= cap_frame;
            if (cap_d0) shadow_d0 <= i_y;
            if (cap_frame) begin
                o_d0 <= shadow_d0;
                o_d1 <= i_y;
            end
        end
    end

`ifdef TDM_DEMUX_ERRCNT_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_err_cnt <= '0;
        end else if (i_err_clr) begin
            o_err_cnt <= '0;
        end else if (o_sync_err && (o_err_cnt != '1)) begin
            o_err_cnt <= o_err_cnt + 1'b1;
        end
    end
`endif

endmodule
